tx_serializer_piso: RTL and testbench

//  Parallel-in/serial-out stage directly downstream of the TX PLL, clocked by the PLL bit-rate clock.

---
 rtl/tx_serdes_pkg.sv | 12 +
 rtl/tx_bit_counter.sv | 96 +++++++++
 rtl/tx_serializer_piso.sv | 87 ++++++++
 tb/tb_tx_serializer_piso.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/tx_serdes_pkg.sv
// Shared types and constants for the TX serializer slice.
package tx_serdes_pkg;

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } tx_state_e;

    // K28.5 with negative running disparity, used as the idle comma.
    localparam logic [9:0] K28_5_RDN = 10'b0011111010;

endpackage

// File: rtl/tx_bit_counter.sv
// Post-reset settle timer and bit-position counter; produces the word
// boundary strobes and the divided word clock for the serializer.
//
//  state  | meaning
//  SETTLE | PLL settling after reset, outputs held quiet
//  RUN    | bit_cnt free-runs 0..DATA_WIDTH-1, words are shifted out
module tx_bit_counter
    import tx_serdes_pkg::*;
#(
    parameter int DATA_WIDTH    = 10,
    parameter int SETTLE_CYCLES = 100
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_run,
    output logic o_boundary,
    output logic o_pre_boundary,
    output logic o_word_clk
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int BW = $clog2(DATA_WIDTH);

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] PRE_BIT     = BW'(DATA_WIDTH - 2);
    localparam logic [BW-1:0] HALF_BIT    = BW'(DATA_WIDTH / 2);

    tx_state_e     r_state;
    tx_state_e     w_state_nxt;
    logic [SW-1:0] r_settle_cnt;
    logic [SW-1:0] w_settle_nxt;
    logic [BW-1:0] r_bit_cnt;
    logic [BW-1:0] w_bit_nxt;
    logic          r_word_clk;
    logic          w_word_clk_nxt;
    logic          w_settle_done;

    assign w_settle_done = (r_settle_cnt == SETTLE_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= SETTLE;
            r_settle_cnt <= '0;
            r_bit_cnt    <= '0;
            r_word_clk   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_bit_cnt    <= w_bit_nxt;
            r_word_clk   <= w_word_clk_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_settle_nxt   = r_settle_cnt;
        w_bit_nxt      = r_bit_cnt;
        w_word_clk_nxt = 1'b0;
        o_pre_boundary = 1'b0;

        case (r_state)
            SETTLE: begin
                if (w_settle_done) begin
                    // First RUN cycle is treated as a word boundary.
                    w_state_nxt    = RUN;
                    w_bit_nxt      = LAST_BIT;
                    o_pre_boundary = 1'b1;
                end else begin
                    w_settle_nxt = r_settle_cnt + SW'(1);
                end
            end
            RUN: begin
                if (r_bit_cnt == LAST_BIT) begin
                    w_bit_nxt = '0;
                end else begin
                    w_bit_nxt = r_bit_cnt + BW'(1);
                end
                o_pre_boundary = (r_bit_cnt == PRE_BIT);
            end
            default: begin
                w_state_nxt = SETTLE;
            end
        endcase

        // Registered from the next count so the high phase lines up with bit 0.
        if (w_state_nxt == RUN) begin
            w_word_clk_nxt = (w_bit_nxt < HALF_BIT);
        end
    end

    assign o_run      = (r_state == RUN);
    assign o_boundary = (r_state == RUN) && (r_bit_cnt == LAST_BIT);
    assign o_word_clk = r_word_clk;

endmodule

// File: rtl/tx_serializer_piso.sv
// Parallel-in/serial-out TX stage: valid/ready word intake, LSB-first shift-out,
// idle comma insertion on underrun with a saturating event counter.
module tx_serializer_piso
    import tx_serdes_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 10,
    parameter int                    SETTLE_CYCLES = 100,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD     = K28_5_RDN,
    parameter int                    CNT_WIDTH     = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_tx_en,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic                  i_data_valid,
    output logic                  o_data_ready,
    output logic                  o_tx_out,
    output logic                  o_word_clk,
    output logic                  o_underrun,
    output logic [CNT_WIDTH-1:0]  o_underrun_cnt
);

    logic                  w_run;
    logic                  w_boundary;
    logic                  w_pre_boundary;
    logic                  w_word_clk;

    logic [DATA_WIDTH-1:0] r_shreg;
    logic [DATA_WIDTH-1:0] w_shreg_nxt;
    logic                  r_data_ready;
    logic                  r_underrun;
    logic [CNT_WIDTH-1:0]  r_underrun_cnt;
    logic [CNT_WIDTH-1:0]  w_underrun_cnt_nxt;
    logic                  w_accept;
    logic                  w_starve;

    tx_bit_counter #(
        .DATA_WIDTH    (DATA_WIDTH),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_bit_counter (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .o_run          (w_run),
        .o_boundary     (w_boundary),
        .o_pre_boundary (w_pre_boundary),
        .o_word_clk     (w_word_clk)
    );

    always_comb begin
        w_accept           = w_boundary & r_data_ready & i_data_valid;
        w_starve           = w_boundary & r_data_ready & ~i_data_valid;
        w_shreg_nxt        = r_shreg;
        w_underrun_cnt_nxt = r_underrun_cnt;

        // A disabled link also gets the comma, but that is not an underrun.
        if (w_boundary) begin
            w_shreg_nxt = w_accept ? i_data_in : IDLE_WORD;
        end else if (w_run) begin
            w_shreg_nxt = r_shreg >> 1;
        end

        if (w_starve && !(&r_underrun_cnt)) begin
            w_underrun_cnt_nxt = r_underrun_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shreg        <= '0;
            r_data_ready   <= 1'b0;
            r_underrun     <= 1'b0;
            r_underrun_cnt <= '0;
        end else begin
            r_shreg        <= w_shreg_nxt;
            r_data_ready   <= w_pre_boundary & i_tx_en;
            r_underrun     <= w_starve;
            r_underrun_cnt <= w_underrun_cnt_nxt;
        end
    end

    assign o_tx_out       = r_shreg[0];
    assign o_data_ready   = r_data_ready;
    assign o_word_clk     = w_word_clk;
    assign o_underrun     = r_underrun;
    assign o_underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_tx_serializer_piso.sv
// Directed bench for tx_serializer_piso: settle timing, word serialization,
// underrun insertion/saturation, TX enable gating and mid-word reset.
module tb_tx_serializer_piso;

    localparam logic [9:0] IDLE = 10'b0011111010;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en;
    logic [9:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       tx_out;
    logic       word_clk;
    logic       underrun;
    logic [7:0] underrun_cnt;

    int n_checks = 0;
    int n_errors = 0;

    tx_serializer_piso #(
        .DATA_WIDTH    (10),
        .SETTLE_CYCLES (100),
        .IDLE_WORD     (10'b0011111010),
        .CNT_WIDTH     (8)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_tx_en        (tx_en),
        .i_data_in      (data_in),
        .i_data_valid   (data_valid),
        .o_data_ready   (data_ready),
        .o_tx_out       (tx_out),
        .o_word_clk     (word_clk),
        .o_underrun     (underrun),
        .o_underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic any_out();
        return data_ready | tx_out | word_clk | underrun | (|underrun_cnt);
    endfunction

    // Called at the falling edge of the first cycle after the last reset edge.
    task automatic release_and_settle(input string tag);
        int bad;
        bad = 0;
        chk({tag, "_reset_state"}, 32'(any_out()), 32'd0);
        rst   = 1'b0;
        tx_en = 1'b1;
        for (int c = 2; c <= 100; c++) begin
            @(negedge clk);
            if (any_out()) bad++;
        end
        chk({tag, "_quiet_cycles"}, 32'(bad), 32'd0);
        @(negedge clk);
        chk({tag, "_ready_cycle101"}, 32'(data_ready), 32'd1);
        chk({tag, "_wclk_cycle101"}, 32'(word_clk), 32'd0);
    endtask

    // Called at the falling edge of a boundary cycle; returns at the next one.
    task automatic run_word(input logic [9:0] d, input logic v, input logic en_mid,
                            output logic [9:0] bits, output logic [9:0] wclk,
                            output logic ur_first, output int ur_rest,
                            output logic rdy_end, output logic [7:0] cnt_end);
        data_in    = d;
        data_valid = v;
        ur_rest    = 0;
        ur_first   = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) data_valid = 1'b0;
            if (k == 3) tx_en = en_mid;
            bits[k] = tx_out;
            wclk[k] = word_clk;
            if (k == 0) ur_first = underrun;
            else ur_rest += int'(underrun);
        end
        rdy_end = data_ready;
        cnt_end = underrun_cnt;
    endtask

    logic [9:0] bits, wclk;
    logic       ur_first, rdy_end;
    int         ur_rest;
    logic [7:0] cnt_end;
    int         pulses, stray;
    logic [7:0] cnt_253, cnt_254;
    logic [4:0] part;

    initial begin
        rst        = 1'b1;
        tx_en      = 1'b0;
        data_in    = '0;
        data_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        release_and_settle("init");

        run_word(10'h2A5, 1'b1, 1'b1, bits, wclk, ur_first, ur_rest, rdy_end, cnt_end);
        chk("w2a5_bits", 32'(bits), 32'h2A5);
        chk("w2a5_underrun", 32'(ur_first) + 32'(ur_rest), 32'd0);
        chk("w2a5_wclk", 32'(wclk), 32'h01F);
        chk("w2a5_ready_next", 32'(rdy_end), 32'd1);

        run_word(10'h155, 1'b0, 1'b1, bits, wclk, ur_first, ur_rest, rdy_end, cnt_end);
        chk("starve_bits", 32'(bits), 32'(IDLE));
        chk("starve_pulse", 32'(ur_first), 32'd1);
        chk("starve_pulse_width", 32'(ur_rest), 32'd0);
        chk("starve_cnt", 32'(cnt_end), 32'd1);

        run_word(10'h3FF, 1'b1, 1'b1, bits, wclk, ur_first, ur_rest, rdy_end, cnt_end);
        chk("ones_bits", 32'(bits), 32'h3FF);
        chk("ones_wclk", 32'(wclk), 32'h01F);
        run_word(10'h000, 1'b1, 1'b1, bits, wclk, ur_first, ur_rest, rdy_end, cnt_end);
        chk("zeros_bits", 32'(bits), 32'h000);
        chk("zeros_wclk", 32'(wclk), 32'h01F);
        chk("zeros_cnt", 32'(cnt_end), 32'd1);

        pulses  = 0;
        stray   = 0;
        cnt_253 = '0;
        cnt_254 = '0;
        for (int i = 0; i < 300; i++) begin
            run_word(10'h0F0, 1'b0, (i == 299) ? 1'b0 : 1'b1,
                     bits, wclk, ur_first, ur_rest, rdy_end, cnt_end);
            pulses += int'(ur_first);
            stray  += ur_rest;
            if (bits !== IDLE) stray++;
            if (i == 252) cnt_253 = cnt_end;
            if (i == 253) cnt_254 = cnt_end;
        end
        chk("sat_cnt_before", 32'(cnt_253), 32'd254);
        chk("sat_cnt_reach", 32'(cnt_254), 32'd255);
        chk("sat_cnt_final", 32'(cnt_end), 32'd255);
        chk("sat_pulses", 32'(pulses), 32'd300);
        chk("sat_last_pulse", 32'(ur_first), 32'd1);
        chk("sat_stray", 32'(stray), 32'd0);
        chk("disable_ready", 32'(rdy_end), 32'd0);

        run_word(10'h3FF, 1'b1, 1'b1, bits, wclk, ur_first, ur_rest, rdy_end, cnt_end);
        chk("disabled_bits", 32'(bits), 32'(IDLE));
        chk("disabled_underrun", 32'(ur_first) + 32'(ur_rest), 32'd0);
        chk("disabled_cnt", 32'(cnt_end), 32'd255);
        chk("reenable_ready", 32'(rdy_end), 32'd1);

        run_word(10'h155, 1'b1, 1'b1, bits, wclk, ur_first, ur_rest, rdy_end, cnt_end);
        chk("w155_bits", 32'(bits), 32'h155);

        data_in    = 10'h2A5;
        data_valid = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k == 0) data_valid = 1'b0;
            part[k] = tx_out;
        end
        chk("midrst_partial", 32'(part), 32'h05);
        rst = 1'b1;
        @(negedge clk);
        release_and_settle("midrst");

        run_word(10'h2A5, 1'b0, 1'b1, bits, wclk, ur_first, ur_rest, rdy_end, cnt_end);
        chk("post_rst_bits", 32'(bits), 32'(IDLE));
        chk("post_rst_cnt", 32'(cnt_end), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
